// File: rtl/pipeline_ctrl.sv
// Front-end pipeline controller: PC, IF/ID register and ID/EX valid, with freeze/redirect/stall/fetch-wait priority.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_hazard_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_imem_valid,
  input  logic            i_dmem_stall,
  output logic [XLEN-1:0] o_pc,
  output logic            o_imem_req,
  output logic [31:0]     o_id_instr,
  output logic [XLEN-1:0] o_id_pc,
  output logic            o_id_valid,
  output logic            o_idex_en,
  output logic            o_ex_valid
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]     o_stall_cycles,
  output logic [31:0]     o_flush_count
`endif
);

  typedef enum logic [2:0] {
    ACT_FREEZE,
    ACT_REDIRECT,
    ACT_STALL,
    ACT_FETCH_WAIT,
    ACT_ADVANCE
  } action_e;

  action_e         action;
  logic            stall;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [31:0]     id_instr_reg, id_instr_next;
  logic [XLEN-1:0] id_pc_reg, id_pc_next;
  logic            id_valid_reg, id_valid_next;
  logic            ex_valid_reg, ex_valid_next;
  logic            unused_pc_lsbs;

  // Redirect targets are forced word-aligned, so the low bits are never consumed.
  assign unused_pc_lsbs = ^i_redirect_pc[1:0];

  // A hazard request against an empty ID slot is meaningless and ignored.
  assign stall = i_hazard_stall & id_valid_reg;

  always_comb begin
    action = ACT_ADVANCE;
    if (i_dmem_stall)       action = ACT_FREEZE;
    else if (i_redirect)    action = ACT_REDIRECT;
    else if (stall)         action = ACT_STALL;
    else if (!i_imem_valid) action = ACT_FETCH_WAIT;
  end

  always_comb begin
    pc_next       = pc_reg;
    id_instr_next = id_instr_reg;
    id_pc_next    = id_pc_reg;
    id_valid_next = id_valid_reg;
    ex_valid_next = ex_valid_reg;
    case (action)
      ACT_REDIRECT: begin
        pc_next       = {i_redirect_pc[XLEN-1:2], 2'b00};
        id_instr_next = NOP_INSTR;
        id_valid_next = 1'b0;
        ex_valid_next = 1'b0;
      end
      ACT_STALL: ex_valid_next = 1'b0;
      ACT_FETCH_WAIT: begin
        id_instr_next = NOP_INSTR;
        id_valid_next = 1'b0;
        ex_valid_next = id_valid_reg;
      end
      ACT_ADVANCE: begin
        pc_next       = pc_reg + XLEN'(4);
        id_instr_next = i_imem_rdata;
        id_pc_next    = pc_reg;
        id_valid_next = 1'b1;
        ex_valid_next = id_valid_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_reg       <= RESET_PC;
      id_instr_reg <= NOP_INSTR;
      id_pc_reg    <= '0;
      id_valid_reg <= 1'b0;
      ex_valid_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      id_instr_reg <= id_instr_next;
      id_pc_reg    <= id_pc_next;
      id_valid_reg <= id_valid_next;
      ex_valid_reg <= ex_valid_next;
    end
  end

  assign o_pc       = pc_reg;
  assign o_id_instr = id_instr_reg;
  assign o_id_pc    = id_pc_reg;
  assign o_id_valid = id_valid_reg;
  assign o_ex_valid = ex_valid_reg;
  assign o_imem_req = ~i_dmem_stall;
  assign o_idex_en  = ~i_dmem_stall;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_count_reg;

  // Saturating counters: a full count sticks rather than wrapping to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if ((action == ACT_FREEZE || action == ACT_STALL) && stall_cycles_reg != '1)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (action == ACT_REDIRECT && flush_count_reg != '1)
        flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cycles_reg;
  assign o_flush_count  = flush_count_reg;
`endif

endmodule
